fetch_queue: RTL and testbench

- Parametrised successor to the single-entry IF/ID pipeline register.
- Buffers up to DEPTH fetched {pc, instruction} pairs between the fetch unit and decode, using valid/ready handshakes on both sides.
- Supports a synchronous flush that discards all entries cleanly (bubbles, never X).
- Whenever the queue is empty, decode sees a canonical NOP.

---
 rtl/fetch_queue.sv | 64 ++++++
 tb/tb_fetch_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry {pc, instruction} FIFO between fetch and decode with sync flush and NOP on empty
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] NOP_INSN = XLEN'(32'h00000013),
  parameter int              CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  instruction_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  instruction,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [XLEN-1:0]  insn_mem [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq, deq;
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign in_ready    = count_q != CNT_W'(DEPTH);
  assign out_valid   = count_q != '0;
  assign count       = count_q;
  assign pc          = out_valid ? pc_mem[head_q] : '0;
  assign instruction = out_valid ? insn_mem[head_q] : NOP_INSN;
  always_comb begin
    enq     = in_valid && in_ready && !flush;
    deq     = out_valid && out_ready && !flush;
    head_d  = flush ? '0 : deq ? inc(head_q) : head_q;
    tail_d  = flush ? '0 : enq ? inc(tail_q) : tail_q;
    count_d = flush ? '0 : (enq && !deq) ? count_q + 1'b1 : (deq && !enq) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail_q]   <= pc_i;
      insn_mem[tail_q] <= instruction_i;
    end
  end
`ifndef SYNTHESIS
  a_count: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(DEPTH));
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid && !in_ready |=> !in_valid || ($stable(pc_i) && $stable(instruction_i)));
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors plus model-checked random stress for fetch_queue (DEPTH 4 and 3)
module tb_fetch_queue;
  localparam logic [31:0] NOP = 32'h00000013;
  logic        clk = 0, rst_n = 0, flush = 0;
  logic        in_valid = 0, out_ready = 0, in_valid3 = 0, out_ready3 = 0;
  logic [31:0] pc_i = 0, insn_i = 0;
  logic        in_ready, out_valid, in_ready3, out_valid3;
  logic [31:0] pc, insn, pc3, insn3;
  logic [2:0]  cnt;
  logic [1:0]  cnt3;
  int          n_chk = 0, n_bad = 0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .instruction_i(insn_i), .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .instruction(insn), .count(cnt)
  );

  fetch_queue #(.DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid3), .in_ready(in_ready3),
    .pc_i(pc_i), .instruction_i(insn_i), .out_valid(out_valid3), .out_ready(out_ready3),
    .pc(pc3), .instruction(insn3), .count(cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    in_valid = 1; pc_i = p; insn_i = i;
    step();
    in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1; out_ready3 = 1;
    repeat (5) step();
    out_ready = 0; out_ready3 = 0;
  endtask

  logic [63:0] q[$];
  logic [31:0] sp;
  bit          m_enq, m_deq;

  initial begin
    // 1: reset then single transfer
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_pc", pc, 0);
    chk("rst_insn", insn, NOP);
    chk("rst_ready", 32'(in_ready), 1);
    rst_n = 1;
    step();
    in_valid = 1; pc_i = 32'h100; insn_i = 32'h00500093;
    chk("pre_enq_insn", insn, NOP);
    step();
    in_valid = 0;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_pc", pc, 32'h100);
    chk("t1_insn", insn, 32'h00500093);
    chk("t1_count", 32'(cnt), 1);
    drain();
    chk("t1_empty", 32'(cnt), 0);
    // 2: fill and backpressure
    for (int i = 0; i < 4; i++) push(32'(i * 4), 32'(32'hA0 + i));
    chk("full_count", 32'(cnt), 4);
    chk("full_ready", 32'(in_ready), 0);
    in_valid = 1; pc_i = 32'h10; insn_i = 32'hBAD;
    step();
    chk("full_hold_count", 32'(cnt), 4);
    chk("full_hold_ready", 32'(in_ready), 0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("fifo_valid", 32'(out_valid), 1);
      chk("fifo_pc", pc, 32'(i * 4));
      chk("fifo_insn", insn, 32'(32'hA0 + i));
      step();
      in_valid = 0;
    end
    out_ready = 0;
    chk("drained_valid", 32'(out_valid), 0);
    chk("drained_count", 32'(cnt), 0);
    chk("drained_insn", insn, NOP);
    // 3: steady enqueue+dequeue at count 2, both depths wrap
    in_valid = 1; in_valid3 = 1;
    for (int i = 0; i < 2; i++) begin
      pc_i = 32'h1000 + 32'(i * 4); insn_i = pc_i ^ 32'hFFFF;
      step();
    end
    out_ready = 1; out_ready3 = 1;
    for (int k = 0; k < 10; k++) begin
      pc_i = 32'h1000 + 32'((k + 2) * 4); insn_i = pc_i ^ 32'hFFFF;
      chk("ss_count", 32'(cnt), 2);
      chk("ss_pc", pc, 32'h1000 + 32'(k * 4));
      chk("ss_insn", insn, (32'h1000 + 32'(k * 4)) ^ 32'hFFFF);
      chk("ss3_count", 32'(cnt3), 2);
      chk("ss3_pc", pc3, 32'h1000 + 32'(k * 4));
      step();
    end
    in_valid = 0; in_valid3 = 0;
    drain();
    chk("ss_empty", 32'(cnt), 0);
    chk("ss3_empty", 32'(cnt3), 0);
    // 4: flush with same-cycle traffic, then held flush
    for (int i = 0; i < 3; i++) push(32'h40 + 32'(i * 4), 32'h7);
    chk("pre_flush_count", 32'(cnt), 3);
    flush = 1; in_valid = 1; out_ready = 1; pc_i = 32'h200;
    step();
    flush = 0; in_valid = 0; out_ready = 0;
    chk("fl_count", 32'(cnt), 0);
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_insn", insn, NOP);
    chk("fl_ready", 32'(in_ready), 1);
    push(32'h204, 32'h33);
    chk("fl_next_pc", pc, 32'h204);
    chk("fl_next_count", 32'(cnt), 1);
    flush = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      pc_i = 32'h600 + 32'(i * 4);
      step();
      chk("flhold_count", 32'(cnt), 0);
      chk("flhold_valid", 32'(out_valid), 0);
    end
    flush = 0; in_valid = 0;
    // 5: asynchronous reset mid-stream
    push(32'h500, 32'h1);
    push(32'h504, 32'h2);
    chk("pre_rst_count", 32'(cnt), 2);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_count", 32'(cnt), 0);
    chk("arst_pc", pc, 0);
    step();
    rst_n = 1;
    push(32'h300, 32'h99);
    chk("post_rst_pc", pc, 32'h300);
    chk("post_rst_count", 32'(cnt), 1);
    drain();
    // 6: random stress against a queue model
    q.delete();
    sp = 32'h8000; pc_i = sp; insn_i = $urandom;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = $urandom_range(0, 99) < 2;
      chk("st_count", 32'(cnt), 32'(q.size()));
      chk("st_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("st_ready", 32'(in_ready), 32'(q.size() != 4));
      chk("st_pc", pc, q.size() != 0 ? q[0][63:32] : 32'h0);
      chk("st_insn", insn, q.size() != 0 ? q[0][31:0] : NOP);
      m_enq = in_valid && q.size() < 4 && !flush;
      m_deq = out_ready && q.size() > 0 && !flush;
      if (flush) q.delete();
      else begin
        if (m_deq) void'(q.pop_front());
        if (m_enq) q.push_back({pc_i, insn_i});
      end
      step();
      if (m_enq) begin
        sp += 4; pc_i = sp; insn_i = $urandom;
      end
    end
    in_valid = 0; out_ready = 0; flush = 0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
